// File: rtl/ps2_rx_controller_pkg.sv
// Shared types and constants for the PS/2 receive controller: frame and
// prefix-decoder state encodings, scancode prefixes and the decoder step.
package ps2_rx_controller_pkg;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_FRAME = 2'd1,
        F_CHECK = 2'd2
    } frame_state_t;

    typedef enum logic [1:0] {
        D_NONE   = 2'd0,
        D_EXT    = 2'd1,
        D_BRK    = 2'd2,
        D_EXTBRK = 2'd3
    } dec_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Strobes counted after the start bit: 8 data, parity, stop.
    localparam logic [3:0] FRAME_BITS = 4'd10;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_PREFIX_EXT) || (b == PS2_PREFIX_BRK);
    endfunction

    // Prefixes accumulate; a repeated prefix leaves the state unchanged.
    function automatic dec_state_t dec_after_prefix(input dec_state_t s, input logic [7:0] b);
        dec_state_t n;
        n = s;
        if (b == PS2_PREFIX_EXT) begin
            if (s == D_NONE)     n = D_EXT;
            else if (s == D_BRK) n = D_EXTBRK;
        end else if (b == PS2_PREFIX_BRK) begin
            if (s == D_NONE)     n = D_BRK;
            else if (s == D_EXT) n = D_EXTBRK;
        end
        return n;
    endfunction

endpackage

// File: rtl/ps2_rx_controller_if.sv
// Key-event output channel. Valid/ready: an event transfers on a cycle where
// key_valid & key_ready are both 1; the source holds key_* stable while key_valid & ~key_ready.
interface ps2_rx_controller_if;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_valid;
    logic       key_ready;

    modport master (
        output key_code, key_ext, key_release, key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code, key_ext, key_release, key_valid,
        output key_ready
    );
endinterface

// File: rtl/ps2_rx_controller_sync_edge.sv
// Synchronises the raw PS/2 clock and data pins and produces a one-cycle
// strobe on each rising edge of the synchronised PS/2 clock.
module ps2_rx_controller_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_raw,
    input  logic data_raw,
    output logic clk_posedge,
    output logic data
);
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_sync_d;

    // Both lines go through equal-depth chains so data stays aligned with the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync   <= '0;
            data_sync  <= '0;
            clk_sync_d <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], clk_raw};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], data_raw};
            clk_sync_d <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_posedge = clk_sync[SYNC_STAGES-1] & ~clk_sync_d;
    assign data        = data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 receive sequencer: frames bytes for the external byte receiver, checks
// parity/stop, enforces a frame timeout and decodes E0/F0 prefixes into key events.
module ps2_rx_controller
    import ps2_rx_controller_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ps2_clk_raw,
    input  logic                       ps2_data_raw,
    output logic                       ps2_clk_posedge,
    output logic                       ps2_data,
    output logic                       start_receiving_data,
    output logic                       rx_abort,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_strb,
    ps2_rx_controller_if.master        key,
    output logic                       err_parity,
    output logic                       err_timeout,
    output logic                       err_overflow,
    output frame_state_t               frame_state,
    output dec_state_t                 dec_state
);
    localparam int                 TIMER_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);

    logic [3:0]         bitcnt;
    logic               parity_acc;
    logic               stop_bit;
    logic [TIMER_W-1:0] timer;
    logic               rx_strb_d;
    logic               rx_strb_rise;
    logic               frame_ok;
    logic               cur_ext;
    logic               cur_brk;

    ps2_rx_controller_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst         (rst),
        .clk_raw     (ps2_clk_raw),
        .data_raw    (ps2_data_raw),
        .clk_posedge (ps2_clk_posedge),
        .data        (ps2_data)
    );

    assign rx_strb_rise = rx_strb & ~rx_strb_d;
    // Odd parity over data+parity, stop high, and exactly a full frame of strobes.
    assign frame_ok     = parity_acc & stop_bit & (bitcnt == FRAME_BITS);
    assign cur_ext      = (dec_state == D_EXT) || (dec_state == D_EXTBRK);
    assign cur_brk      = (dec_state == D_BRK) || (dec_state == D_EXTBRK);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_state          <= F_IDLE;
            dec_state            <= D_NONE;
            bitcnt               <= '0;
            parity_acc           <= 1'b0;
            stop_bit             <= 1'b0;
            timer                <= '0;
            rx_strb_d            <= 1'b0;
            start_receiving_data <= 1'b0;
            rx_abort             <= 1'b0;
            err_parity           <= 1'b0;
            err_timeout          <= 1'b0;
            err_overflow         <= 1'b0;
            key.key_code         <= '0;
            key.key_ext          <= 1'b0;
            key.key_release      <= 1'b0;
            key.key_valid        <= 1'b0;
        end else begin
            rx_strb_d            <= rx_strb;
            start_receiving_data <= 1'b0;
            rx_abort             <= 1'b0;
            err_parity           <= 1'b0;
            err_timeout          <= 1'b0;
            err_overflow         <= 1'b0;

            if (key.key_valid && key.key_ready) begin
                key.key_valid <= 1'b0;
            end

            unique case (frame_state)
                F_IDLE: begin
                    if (ps2_clk_posedge && !ps2_data) begin
                        start_receiving_data <= 1'b1;
                        bitcnt               <= '0;
                        parity_acc           <= 1'b0;
                        stop_bit             <= 1'b0;
                        timer                <= '0;
                        frame_state          <= F_FRAME;
                    end
                end

                F_FRAME: begin
                    if (ps2_clk_posedge) begin
                        timer <= '0;
                        if (bitcnt < 4'd9) parity_acc <= parity_acc ^ ps2_data;
                        if (bitcnt == 4'd9) stop_bit <= ps2_data;
                        if (bitcnt != 4'hF) bitcnt <= bitcnt + 4'd1;
                    end else if (timer != TIMER_MAX) begin
                        timer <= timer + TIMER_W'(1);
                    end

                    if (rx_strb_rise) begin
                        frame_state <= F_CHECK;
                    end else if (timer == TIMER_MAX) begin
                        err_timeout <= 1'b1;
                        rx_abort    <= 1'b1;
                        dec_state   <= D_NONE;
                        frame_state <= F_IDLE;
                    end
                end

                F_CHECK: begin
                    rx_abort    <= 1'b1;
                    frame_state <= F_IDLE;
                    if (!frame_ok) begin
                        err_parity <= 1'b1;
                        dec_state  <= D_NONE;
                    end else if (is_prefix(rx_data)) begin
                        dec_state <= dec_after_prefix(dec_state, rx_data);
                    end else begin
                        dec_state <= D_NONE;
                        // A held, unaccepted event wins; the new one is dropped.
                        if (key.key_valid && !key.key_ready) begin
                            err_overflow <= 1'b1;
                        end else begin
                            key.key_code    <= rx_data;
                            key.key_ext     <= cur_ext;
                            key.key_release <= cur_brk;
                            key.key_valid   <= 1'b1;
                        end
                    end
                end

                default: frame_state <= F_IDLE;
            endcase
        end
    end

endmodule
